// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_pkg                                                          |
// | Brief   : Shared constants and types for the dCPU front end.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_RESET  = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_fifo                                                       |
// | Brief   : Synchronous FIFO with flush, occupancy count and a head word     |
// |           taken straight from storage registers.                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next pointers/count; a flush empties the buffer and overrides push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_unit                                                       |
// | Brief   : Instruction fetch stage: sequential PC generation, in-order      |
// |           imem requests, instruction buffer, redirect and halt handling.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] fifo_head;
  logic            run, pop, halt_fire, redirect_take;
  logic            req_fire, push, flush;
  logic [CW:0]     slots_used;
  logic [XLEN-1:0] redirect_target;

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (imem_rsp_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Handshake decode, outputs and next-state; halt takes priority over redirect.
  always_comb begin
    run             = (state_q == FS_RUN);
    redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    ir_valid        = run && (fifo_count != '0);
    ir              = (fifo_count != '0) ? fifo_head : NOP_INSN;
    pc              = out_pc_q;
    halted          = (state_q == FS_HALTED);
    pop             = ir_valid && ir_ready;
    halt_fire       = pop && halt_in;
    redirect_take   = run && redirect_valid && !halt_fire;
    flush           = redirect_take || halt_fire;
    // A slot freed by this cycle's pop may be reused immediately.
    slots_used      = {1'b0, outstanding_q} + {1'b0, fifo_count} - (CW+1)'(pop);
    imem_req_valid  = run && !redirect_valid && (slots_used < (CW+1)'(FIFO_DEPTH));
    imem_addr       = fetch_pc_q;
    req_fire        = imem_req_valid && imem_req_ready;
    push            = imem_rsp_valid && run && !flush && (drop_cnt_q == '0);

    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    out_pc_d      = out_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;

    case (state_q)
      FS_RESET: state_d = FS_RUN;
      FS_RUN:   if (halt_fire) state_d = FS_HALTED;
      default:  state_d = FS_HALTED;
    endcase

    if (redirect_take) begin
      fetch_pc_d = redirect_target;
      out_pc_d   = redirect_target;
      // Everything still outstanding after this edge belongs to the old path.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (pop)      out_pc_d   = out_pc_q + 32'd4;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FS_RESET;
      fetch_pc_q    <= RESET_PC;
      out_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      out_pc_q      <= out_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_unit                                                    |
// | Brief   : Randomised self-checking bench for fetch_unit with an in-order   |
// |           memory model and a queue-based instruction stream reference.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_in = 1'b0;
  logic        ir_valid, ir_ready = 1'b0;
  logic [31:0] ir, pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_in(halt_in),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .pc(pc), .halted(halted)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];        // accepted requests awaiting their response
  logic [31:0] ibuf[$];      // addresses of fetched, still-valid, undelivered words
  logic [31:0] fire_log[$];
  logic [31:0] exp_fetch, exp_pc, last_pop_pc;
  bit          halted_m;
  int          cyc, n_cmp, n_err, n_fire, n_pop;
  int          lat, p_rdy, p_irr, p_redir;
  bit          halt_arm, redir_on_halt, force_redir;
  logic [31:0] halt_pc, force_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check_val({tag, "_addr"},      imem_addr,               RST_PC);
    check_val({tag, "_ir_valid"},  {31'b0, ir_valid},       32'd0);
    check_val({tag, "_ir"},        ir,                      NOP);
    check_val({tag, "_pc"},        pc,                      RST_PC);
    check_val({tag, "_halted"},    {31'b0, halted},         32'd0);
  endtask

  // Asynchronous reset asserted away from the clock edge, then released.
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; ir_ready = 1'b0;
    redirect_valid = 1'b0; halt_in = 1'b0;
    mq.delete(); ibuf.delete(); fire_log.delete();
    exp_fetch = RST_PC; exp_pc = RST_PC; halted_m = 1'b0;
    halt_arm = 1'b0; redir_on_halt = 1'b0; force_redir = 1'b0;
    n_fire = 0; n_pop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("req_in_first_cycle", {31'b0, imem_req_valid}, 32'd0);
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference.
  task automatic step();
    bit          rsp_now, rv, hv, e_valid, e_req, pop_m, halt_f, redir_t;
    logic [31:0] rpc;
    int          due;
    @(posedge clk); #1;
    cyc++;
    rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : $urandom;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    ir_ready       = ($urandom_range(99) < p_irr);
    rv             = ($urandom_range(99) < p_redir);
    rpc            = $urandom & 32'h0000_3FFF;
    if (force_redir) begin
      rv = 1'b1; rpc = force_target; force_redir = 1'b0; fire_log.delete();
    end
    hv = halt_arm && (ibuf.size() > 0) && (ibuf[0] == halt_pc);
    if (hv && redir_on_halt) begin
      rv = 1'b1; rpc = 32'h0000_2000;
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_in        = hv;
    @(negedge clk);

    e_valid = !halted_m && (ibuf.size() > 0);
    pop_m   = e_valid && ir_ready;
    e_req   = !halted_m && !rv && ((mq.size() + ibuf.size() - int'(pop_m)) < DEPTH);
    check_val("ir_valid",  {31'b0, ir_valid},       {31'b0, e_valid});
    check_val("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
    check_val("halted",    {31'b0, halted},         {31'b0, halted_m});
    if (e_valid) check_val("ir", ir, mem_word(ibuf[0]));
    else         check_val("ir_nop", ir, NOP);
    if (!halted_m) check_val("pc", pc, exp_pc);
    if (e_req)     check_val("addr", imem_addr, exp_fetch);

    halt_f  = pop_m && hv;
    redir_t = !halted_m && rv && !halt_f;
    if (pop_m) begin
      last_pop_pc = exp_pc;
      void'(ibuf.pop_front());
      exp_pc += 32'd4;
      n_pop++;
    end
    if (halt_f || redir_t) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      ibuf.delete();
    end
    if (redir_t) begin
      exp_fetch = rpc & ~32'd3;
      exp_pc    = rpc & ~32'd3;
    end
    if (halt_f) halted_m = 1'b1;
    if (rsp_now) begin
      mreq_t r;
      r = mq.pop_front();
      if (!r.stale && !halted_m) ibuf.push_back(r.addr);
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
      mq.push_back('{addr: imem_addr, due: due, stale: 1'b0});
      fire_log.push_back(imem_addr);
      exp_fetch += 32'd4;
      n_fire++;
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] held;
    cyc = 0; n_cmp = 0; n_err = 0; last_pop_pc = '0;
    lat = 1; p_rdy = 100; p_irr = 100; p_redir = 0;

    // Streaming with 1-cycle memory and an always-ready decoder.
    do_reset();
    repeat (3) step();
    check_val("first_req0", fire_log[0], 32'h0);
    check_val("first_req1", fire_log[1], 32'h4);
    check_val("first_req2", fire_log[2], 32'h8);
    repeat (5) step();
    cnt = n_pop;
    repeat (20) step();
    check_val("throughput", n_pop - cnt, 32'd20);

    // Decoder stalled: buffer plus in-flight fill to exactly the depth.
    do_reset();
    p_irr = 0;
    repeat (12) step();
    check_val("stall_fires", n_fire, DEPTH);
    check_val("stall_req_low", {31'b0, imem_req_valid}, 32'd0);
    p_irr = 100;
    repeat (10) step();
    check_val("resume_fetch", {31'b0, n_fire > DEPTH}, 32'd1);

    // 3-cycle memory, redirect with two requests in flight.
    do_reset();
    lat = 3;
    cnt = 0;
    while (mq.size() != 2 && cnt < 10) begin step(); cnt++; end
    check_val("two_in_flight", mq.size(), 32'd2);
    force_redir = 1'b1; force_target = 32'h0000_0103;
    step();
    cnt = 0;
    while (n_pop == 0 && cnt < 30) begin step(); cnt++; end
    check_val("redir_first_pc", last_pop_pc, 32'h0000_0100);

    // Memory back-pressure: request address held.
    p_rdy = 0;
    step();
    held = imem_addr;
    repeat (5) step();
    check_val("addr_held", imem_addr, held);
    p_rdy = 100;
    repeat (5) step();

    // Halt on pc 0x8 with a simultaneous redirect.
    do_reset();
    lat = 1; halt_arm = 1'b1; halt_pc = 32'h8; redir_on_halt = 1'b1;
    cnt = 0;
    while (!halted_m && cnt < 20) begin step(); cnt++; end
    check_val("halt_reached", {31'b0, halted_m}, 32'd1);
    cnt = n_fire;
    step();
    p_redir = 50;
    repeat (8) step();
    check_val("halted_no_fire", n_fire - cnt, 32'd0);
    check_val("halted_out", {31'b0, halted}, 32'd1);
    p_redir = 0;

    // Address wrap at the top of memory.
    do_reset();
    force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
    repeat (8) step();
    check_val("wrap0", fire_log[0], 32'hFFFF_FFF8);
    check_val("wrap1", fire_log[1], 32'hFFFF_FFFC);
    check_val("wrap2", fire_log[2], 32'h0000_0000);

    // Randomised segments, each ended by an asynchronous reset mid-stream.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      lat     = $urandom_range(1, 3);
      p_rdy   = $urandom_range(40, 100);
      p_irr   = $urandom_range(30, 100);
      p_redir = 4;
      halt_arm = seg[0];
      halt_pc  = ($urandom_range(4, 40)) << 2;
      repeat (300) step();
      check_val("liveness", {31'b0, n_pop > 0}, 32'd1);
    end
    p_redir = 0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the dCPU core, directly upstream of the decoder. Generates sequential PCs, issues word reads to instruction memory over a valid/ready request channel, buffers returned words in a small FIFO, and presents one `ir`/`pc` pair per handshake to the decoder. Handles control-flow redirects and the decoder's halt indication, discarding stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `FIFO_DEPTH`, 4, instruction buffer entries and max in-flight requests; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  word-aligned request address.
- `imem_rsp_valid`  in  1  read data returned, in request order; always accepted.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  control-flow change (branch/jump resolved).
- `redirect_pc`  in  32  new fetch target; bits [1:0] forced to 0.
- `halt_in`  in  1  decoder `is_halt` for the currently presented `ir`.
- `ir_valid`  out  1  `ir`/`pc` valid.
- `ir_ready`  in  1  decoder consumes.
- `ir`  out  32  instruction to decoder.
- `pc`  out  32  address of `ir`.
- `halted`  out  1  fetch permanently stopped.

## Operation
- States: RESET → RUN (unconditionally, first cycle after `rst_n` rises) → HALTED (on halt). HALTED exits only via reset.
- Registers: `fetch_pc` (next request address), `out_pc` (address of FIFO head), `outstanding` (in-flight count), `drop_cnt` (responses to discard).
- Request: in RUN, `imem_req_valid` = 1 when `outstanding + fifo_count − pop < FIFO_DEPTH` and no redirect this cycle. `imem_addr` = `fetch_pc`. On `valid & ready`: `fetch_pc += 4` (wraps mod 2^32), `outstanding++`. `imem_req_valid`/`imem_addr` stay stable until accepted unless a redirect occurs.
- Response: `outstanding--`. If `drop_cnt > 0`: discard, `drop_cnt--`; else push into FIFO.
- Output: `ir_valid` = FIFO non-empty and state RUN; `ir` = head, or 32'h0000_0013 (NOP) when empty; `pc` = `out_pc`. Pop on `ir_valid & ir_ready`; `out_pc += 4`.
- Redirect (RUN only): `fetch_pc` and `out_pc` ← `redirect_pc & ~3`; FIFO flushed; `drop_cnt` ← all requests in flight after this cycle, and any response arriving this cycle is discarded; no request issued this cycle; a same-cycle pop still completes.
- Halt: when `halt_in & ir_valid & ir_ready`, go HALTED: FIFO flushed, `ir_valid` = 0, no further requests, remaining responses dropped, `halted` = 1.
- Simultaneous redirect and halt: halt wins, redirect ignored. Redirect in HALTED ignored.
- Reset mid-operation: all state cleared asynchronously; responses already in flight are the memory's responsibility to cancel.

## Timing
- Reset values: `imem_req_valid` 0, `imem_addr` `RESET_PC`, `ir_valid` 0, `ir` 32'h0000_0013, `pc` `RESET_PC`, `halted` 0; all counters 0.
- `imem_req_valid` first asserted in the 2nd cycle after `rst_n` deassertion.
- Response pushed at the clock edge it arrives; `ir_valid` asserted the following cycle (FIFO is registered, no bypass). Minimum request→`ir_valid` latency: memory latency + 1.
- With 1-cycle memory, always-ready decoder and `FIFO_DEPTH` ≥ 2: sustained one instruction per cycle.
- Redirect at cycle t: `ir_valid` = 0 at t+1; first request to target at t+1.
- `halted` rises the cycle after the halting handshake.

## Structure
- Shared package `cpu_pkg`: `NOP_INSN` = 32'h0000_0013, default `RESET_PC`, fetch state enum (`FS_RESET`, `FS_RUN`, `FS_HALTED`), `XLEN` = 32.
- One sub-module: `fetch_fifo` — synchronous FIFO, parameterised width/depth, push/pop/flush, count output, registered read data.

## Test plan
- Reset release, 1-cycle memory, `ir_ready`=1 -> requests 0x0,0x4,0x8 on consecutive cycles; `ir_valid` from cycle 3, `pc` 0x0,0x4,0x8 back-to-back.
- `ir_ready`=0 for 10 cycles -> exactly `FIFO_DEPTH` requests issued, then `imem_req_valid`=0; release -> 4 words delivered in order, fetching resumes.
- 3-cycle memory, redirect to 0x103 with 2 requests in flight -> both stale responses dropped; next `pc` 0x100 with data from 0x100.
- `imem_req_ready`=0 for 5 cycles -> `imem_addr` held constant, `fetch_pc` unchanged.
- `halt_in` on handshake of `pc` 0x8, same-cycle redirect -> `halted`=1 next cycle, `ir_valid` stays 0, no further requests, redirect ignored.
- `fetch_pc` 0xFFFF_FFFC -> next request 0x0000_0000; async reset asserted mid-stream -> all outputs at reset values immediately.
